// File: rtl/battle_ctrl_gen.sv
// ---------------------------------------------------------------------------
// battle_ctrl_gen
// Turn-based battle controller for TEAM_SIZE mons per side. It keeps per-slot
// HP, runs the move menu, resolves turn order and accuracy, applies
// saturating damage and handles faint/switch. Stat lookup, damage calculation
// and rendering live outside this block.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   start               begin a battle (honoured in IDLE only)
//   keycode             USB keycode, edge-detected (W/A/S/D/ENTER)
//   rand_num            free-running random value used for accuracy rolls
//   p_max_hp, e_max_hp  max HP of the active slot on each side
//   p_speed, e_speed    speed of the active mons
//   p_acc, e_acc        accuracy of the selected move, 0..100
//   dmg                 damage for the side picked by attacker_is_player
//   attacker_is_player  damage-calc select, high only in P_HIT
//   cur_mon, opp_mon    active slot per side
//   move_index          highlighted move in the menu grid
//   p_hp, e_hp          current HP of the active slots
//   state               FSM state encoding
//   done, result        end-of-battle pulse and win flag
// ---------------------------------------------------------------------------
module battle_ctrl_gen #(
    parameter int unsigned TEAM_SIZE = 3,
    parameter int unsigned HP_W      = 8,
    parameter int unsigned NUM_MOVES = 4,
    parameter int unsigned MOVE_COLS = 2,
    localparam int unsigned IDX_W    = $clog2(TEAM_SIZE),
    localparam int unsigned MI_W     = $clog2(NUM_MOVES)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [7:0]        keycode,
    input  logic [7:0]        rand_num,
    input  logic [HP_W-1:0]   p_max_hp,
    input  logic [HP_W-1:0]   e_max_hp,
    input  logic [7:0]        p_speed,
    input  logic [7:0]        e_speed,
    input  logic [6:0]        p_acc,
    input  logic [6:0]        e_acc,
    input  logic [HP_W-1:0]   dmg,
    output logic              attacker_is_player,
    output logic [IDX_W-1:0]  cur_mon,
    output logic [IDX_W-1:0]  opp_mon,
    output logic [MI_W-1:0]   move_index,
    output logic [HP_W-1:0]   p_hp,
    output logic [HP_W-1:0]   e_hp,
    output logic [3:0]        state,
    output logic              done,
    output logic              result
);

    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(TEAM_SIZE - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_P = 4'd1,
        S_LOAD_E = 4'd2,
        S_SELECT = 4'd3,
        S_ORDER  = 4'd4,
        S_P_HIT  = 4'd5,
        S_E_HIT  = 4'd6,
        S_P_TEXT = 4'd7,
        S_E_TEXT = 4'd8,
        S_FAINT  = 4'd9,
        S_WIN    = 4'd10,
        S_LOSE   = 4'd11
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_prev_key;
    logic [IDX_W-1:0]    r_cur_mon;
    logic [IDX_W-1:0]    r_opp_mon;
    logic [MI_W-1:0]     r_move_idx;
    logic [HP_W-1:0]     r_p_hp [TEAM_SIZE];
    logic [HP_W-1:0]     r_e_hp [TEAM_SIZE];
    logic                r_player_first;
    logic                r_init_load;
    logic                r_result;

    logic                w_press;
    logic                w_enter;
    logic [HP_W-1:0]     w_p_hp;
    logic [HP_W-1:0]     w_e_hp;
    logic [6:0]          w_roll;
    logic                w_p_hits;
    logic                w_e_hits;
    logic [HP_W-1:0]     w_p_hp_dmg;
    logic [HP_W-1:0]     w_e_hp_dmg;
    int unsigned         w_mi;
    int unsigned         w_col;

    // One action per physical press: a new non-zero keycode
    assign w_press = (keycode != r_prev_key) && (keycode != 8'h00);
    assign w_enter = w_press && (keycode == KEY_ENTER);

    assign w_p_hp = r_p_hp[r_cur_mon];
    assign w_e_hp = r_e_hp[r_opp_mon];

    // Roll in 1..100; the move lands when the roll does not exceed accuracy
    assign w_roll   = 7'(rand_num % 8'd100) + 7'd1;
    assign w_p_hits = (w_roll <= p_acc);
    assign w_e_hits = (w_roll <= e_acc);

    // Damage saturates at zero HP
    assign w_e_hp_dmg = (dmg >= w_e_hp) ? '0 : (w_e_hp - dmg);
    assign w_p_hp_dmg = (dmg >= w_p_hp) ? '0 : (w_p_hp - dmg);

    assign w_mi  = 32'(r_move_idx);
    assign w_col = w_mi % MOVE_COLS;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD_P;
            S_LOAD_P: w_next = r_init_load ? S_LOAD_E : S_SELECT;
            S_LOAD_E: w_next = S_SELECT;
            S_SELECT: if (w_enter) w_next = S_ORDER;
            S_ORDER:  w_next = (p_speed >= e_speed) ? S_P_HIT : S_E_HIT;
            S_P_HIT:  w_next = S_P_TEXT;
            S_E_HIT:  w_next = S_E_TEXT;
            S_P_TEXT: if (w_enter) begin
                if (w_e_hp == '0)        w_next = S_FAINT;
                else if (r_player_first) w_next = S_E_HIT;
                else                     w_next = S_SELECT;
            end
            S_E_TEXT: if (w_enter) begin
                if (w_p_hp == '0)         w_next = S_FAINT;
                else if (!r_player_first) w_next = S_P_HIT;
                else                      w_next = S_SELECT;
            end
            S_FAINT: begin
                if (w_e_hp == '0)
                    w_next = (r_opp_mon == LAST_SLOT) ? S_WIN : S_LOAD_E;
                else
                    w_next = (r_cur_mon == LAST_SLOT) ? S_LOSE : S_LOAD_P;
            end
            S_WIN:    w_next = S_IDLE;
            S_LOSE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        attacker_is_player = 1'b0;
        done               = 1'b0;
        case (r_state)
            S_P_HIT: attacker_is_player = 1'b1;
            S_WIN,
            S_LOSE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: key history, indices, menu cursor, HP slots, result
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_prev_key     <= 8'h00;
            r_cur_mon      <= '0;
            r_opp_mon      <= '0;
            r_move_idx     <= '0;
            r_player_first <= 1'b0;
            r_init_load    <= 1'b0;
            r_result       <= 1'b0;
            for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
                r_p_hp[i] <= '0;
                r_e_hp[i] <= '0;
            end
        end else begin
            r_prev_key <= keycode;
            case (r_state)
                S_IDLE: if (start) begin
                    r_cur_mon   <= '0;
                    r_opp_mon   <= '0;
                    r_move_idx  <= '0;
                    r_result    <= 1'b0;
                    r_init_load <= 1'b1;
                    for (int unsigned i = 0; i < TEAM_SIZE; i++) begin
                        r_p_hp[i] <= '0;
                        r_e_hp[i] <= '0;
                    end
                end
                S_LOAD_P: r_p_hp[r_cur_mon] <= p_max_hp;
                S_LOAD_E: begin
                    r_e_hp[r_opp_mon] <= e_max_hp;
                    r_init_load       <= 1'b0;
                end
                S_SELECT: if (w_press) begin
                    // Cursor stops at grid edges instead of wrapping
                    case (keycode)
                        KEY_W: if (w_mi >= MOVE_COLS)
                            r_move_idx <= r_move_idx - MI_W'(MOVE_COLS);
                        KEY_S: if (w_mi + MOVE_COLS < NUM_MOVES)
                            r_move_idx <= r_move_idx + MI_W'(MOVE_COLS);
                        KEY_A: if (w_col != 0)
                            r_move_idx <= r_move_idx - MI_W'(1);
                        KEY_D: if (w_col != MOVE_COLS - 1)
                            r_move_idx <= r_move_idx + MI_W'(1);
                        default: ;
                    endcase
                end
                S_ORDER: r_player_first <= (p_speed >= e_speed);
                S_P_HIT: if (w_p_hits) r_e_hp[r_opp_mon] <= w_e_hp_dmg;
                S_E_HIT: if (w_e_hits) r_p_hp[r_cur_mon] <= w_p_hp_dmg;
                S_FAINT: begin
                    r_move_idx <= '0;
                    if (w_e_hp == '0) begin
                        if (r_opp_mon != LAST_SLOT) r_opp_mon <= r_opp_mon + IDX_W'(1);
                    end else if (r_cur_mon != LAST_SLOT) begin
                        r_cur_mon <= r_cur_mon + IDX_W'(1);
                    end
                end
                S_WIN:  r_result <= 1'b1;
                S_LOSE: r_result <= 1'b0;
                default: ;
            endcase
        end
    end

    assign cur_mon    = r_cur_mon;
    assign opp_mon    = r_opp_mon;
    assign move_index = r_move_idx;
    assign p_hp       = w_p_hp;
    assign e_hp       = w_e_hp;
    assign state      = r_state;
    assign result     = r_result;

endmodule
